vram_scroller: RTL

Hardware text-screen engine that clears or scrolls the 1 KB text VRAM without CPU byte loops. It sits directly upstream of the VRAM wrapper and drives both SDPB ports: it issues reads on port B and writes the copied or fill bytes on port A. The CPU-side bus decoder muxes its own VRAM writes with this block's outputs whenever `busy` is high.

---
 rtl/vram_scroller.sv | 131 +++++++++++++
 1 files changed

// File: rtl/vram_scroller.sv
// Text-screen clear/scroll engine for the 1 KB VRAM.
// Reads on port B, writes copied or fill bytes on port A.
module vram_scroller #(
   parameter int COLS = 60,
   parameter int ROWS = 17
) (
   input  logic       MEMORY_CLK,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_op,
   input  logic [7:0] cmd_fill,
   output logic       busy,
   output logic       done,
   output logic       v_cea,
   output logic [9:0] v_ada,
   output logic [7:0] v_din,
   output logic       v_ceb,
   output logic       v_oce,
   output logic [9:0] v_adb,
   input  logic [7:0] v_dout
);

   localparam int N = COLS * ROWS;

   generate
      if (N > 1024 || N < 1) begin : g_size_check
         $error("vram_scroller: COLS*ROWS must be in 1..1024");
      end
   endgenerate

   localparam logic [9:0] LAST_A = 10'(N - 1);
   localparam logic [9:0] COLS_A = 10'(COLS);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_COPY, S_DRAIN, S_FILL, S_DONE} state_t;

   state_t     state, state_nxt;
   logic       cea_nxt, ceb_nxt, busy_nxt, done_nxt;
   logic [9:0] ada_nxt, adb_nxt;
   logic [7:0] fill_q;
   logic       accept;

   assign accept    = cmd_valid && !busy;
   assign cmd_ready = ~busy;
   assign v_oce     = busy;
   assign v_din     = (state == S_COPY || state == S_DRAIN) ? v_dout : fill_q;

   always_comb begin
      state_nxt = state;
      cea_nxt   = 1'b0;
      ceb_nxt   = 1'b0;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      ada_nxt   = v_ada;
      adb_nxt   = v_adb;
      case (state)
         S_IDLE, S_DONE: begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
            if (accept) begin
               busy_nxt = 1'b1;
               // a one-row screen has nothing to copy, so scroll degenerates to clear
               if (cmd_op && ROWS > 1) begin
                  state_nxt = S_COPY;
                  ceb_nxt   = 1'b1;
                  adb_nxt   = COLS_A;
               end else begin
                  state_nxt = S_CLEAR;
                  cea_nxt   = 1'b1;
                  ada_nxt   = '0;
               end
            end
         end
         S_CLEAR, S_FILL: begin
            if (v_ada == LAST_A) begin
               state_nxt = S_DONE;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
            end else begin
               cea_nxt = 1'b1;
               ada_nxt = v_ada + 10'd1;
            end
         end
         S_COPY: begin
            // the byte read this cycle lands one row up on the next cycle
            cea_nxt = 1'b1;
            ada_nxt = v_adb - COLS_A;
            if (v_adb == LAST_A) begin
               state_nxt = S_DRAIN;
            end else begin
               ceb_nxt = 1'b1;
               adb_nxt = v_adb + 10'd1;
            end
         end
         S_DRAIN: begin
            state_nxt = S_FILL;
            cea_nxt   = 1'b1;
            ada_nxt   = v_ada + 10'd1;
         end
         default: begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         v_cea <= 1'b0;
         v_ceb <= 1'b0;
         v_ada <= '0;
         v_adb <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         v_cea <= cea_nxt;
         v_ceb <= ceb_nxt;
         v_ada <= ada_nxt;
         v_adb <= adb_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

   always_ff @(posedge MEMORY_CLK) begin
      if (accept) fill_q <= cmd_fill;
   end

endmodule
